// File: rtl/rep_sum_engine_if.sv
// Handshake bundle between the range parser, rep_sum_engine and the answer accumulator.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface rep_sum_engine_if #(
    parameter int WIDTH     = 64,
    parameter int SUM_WIDTH = 128
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     n_in;
    logic                 mode_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [SUM_WIDTH-1:0] sum_out;
    logic                 busy;

    // Request producer and result consumer.
    modport master (
        output in_valid, n_in, mode_in, out_ready,
        input  in_ready, out_valid, sum_out, busy
    );

    // The engine itself.
    modport slave (
        input  in_valid, n_in, mode_in, out_ready,
        output in_ready, out_valid, sum_out, busy
    );
endinterface

// File: rtl/rep_sum_engine.sv
// Sums every repeated-block ID x in 1..n (mode 0: block twice, mode 1: block twice or more).
// Latency: variable, roughly digits * terms * (WIDTH + 25) cycles; one request in flight.
// Backpressure: in_ready low while busy; result held on sum_out until out_ready.
module rep_sum_engine #(
    parameter int WIDTH     = 64,
    parameter int SUM_WIDTH = 128
) (
    input  logic           clock,
    input  logic           reset,
    rep_sum_engine_if.slave bus
);
    // PW holds powers of ten up to 10*n; RW is one bit wider for the divider shift.
    localparam int PW = WIDTH + 4;
    localparam int RW = PW + 1;
    localparam int MW = 2 * WIDTH;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DIGS,
        S_TERMS,
        S_POW,
        S_BASE,
        S_DIV,
        S_RANGE,
        S_MUL1,
        S_MUL2,
        S_ACC,
        S_DONE
    } state_t;

    state_t               state;

    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic [SUM_WIDTH-1:0] sum_out_r;

    logic [WIDTH-1:0]     n_r;
    logic                 mode_r;
    logic [SUM_WIDTH-1:0] acc;

    // digit counting
    logic [4:0]           dig_cnt;
    logic [PW-1:0]        dig_pow;
    logic [4:0]           d_cur;

    // term list for the current digit count
    logic [3:0][4:0]      t_q;
    logic [3:0]           t_neg;
    logic [1:0]           n_terms;
    logic [1:0]           t_idx;

    // block-size powers and repunit-style base
    logic [4:0]           q_acc;
    logic [4:0]           base_cnt;
    logic [PW-1:0]        pw_lo;
    logic [PW-1:0]        pw_hi;
    logic [PW-1:0]        base;

    // divider
    logic [WIDTH-1:0]     dvd;
    logic [PW-1:0]        rem;
    logic [WIDTH-1:0]     quo;
    logic [6:0]           div_cnt;

    // term arithmetic
    logic [PW-1:0]        lb_r;
    logic [PW-1:0]        ub_r;
    logic                 live_r;
    logic [MW-1:0]        half_r;
    logic [SUM_WIDTH-1:0] term_r;

    // combinational helpers
    logic [4:0]           p1;
    logic [4:0]           p2;
    logic [4:0]           p12;
    logic                 two_primes;
    logic [4:0]           cur_q;
    logic                 cur_neg;
    logic [PW-1:0]        hi_m1;
    logic [PW-1:0]        quo_ext;
    logic [PW-1:0]        ub_sel;
    logic [RW-1:0]        rem_shift;
    logic                 rem_ge;
    logic [PW:0]          s_w;
    logic [PW-1:0]        cnt_w;
    logic [SUM_WIDTH-1:0] acc_upd;
    logic [4:0]           d_next;
    logic                 more_d;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sum_out   = sum_out_r;

    assign cur_q     = t_q[t_idx];
    assign cur_neg   = t_neg[t_idx];
    assign hi_m1     = pw_hi - PW'(1);
    assign quo_ext   = {4'b0000, quo};
    assign ub_sel    = (quo_ext < hi_m1) ? quo_ext : hi_m1;
    assign rem_shift = {rem, dvd[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, base};
    assign s_w       = {1'b0, lb_r} + {1'b0, ub_r};
    assign cnt_w     = ub_r - lb_r + PW'(1);
    assign acc_upd   = cur_neg ? (acc - term_r) : (acc + term_r);
    assign d_next    = d_cur + 5'd1;
    assign more_d    = d_next <= dig_cnt;

    function automatic logic [PW-1:0] times10(input logic [PW-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

    // Distinct prime factors of the current digit count (d <= 20, so at most two).
    always_comb begin
        p1         = '0;
        p2         = '0;
        p12        = '0;
        two_primes = 1'b0;
        case (d_cur)
            5'd2, 5'd4, 5'd8, 5'd16: p1 = 5'd2;
            5'd3, 5'd9:              p1 = 5'd3;
            5'd5, 5'd7, 5'd11, 5'd13, 5'd17, 5'd19: p1 = d_cur;
            5'd6, 5'd12, 5'd18: begin
                p1 = 5'd2; p2 = 5'd3; p12 = 5'd6; two_primes = 1'b1;
            end
            5'd10, 5'd20: begin
                p1 = 5'd2; p2 = 5'd5; p12 = 5'd10; two_primes = 1'b1;
            end
            5'd14: begin
                p1 = 5'd2; p2 = 5'd7; p12 = 5'd14; two_primes = 1'b1;
            end
            5'd15: begin
                p1 = 5'd3; p2 = 5'd5; p12 = 5'd15; two_primes = 1'b1;
            end
            default: begin
                p1 = '0;
            end
        endcase
    end

    // Control FSM and datapath: every register, including the outputs, updates here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            sum_out_r   <= '0;
            n_r         <= '0;
            mode_r      <= 1'b0;
            acc         <= '0;
            dig_cnt     <= '0;
            dig_pow     <= '0;
            d_cur       <= '0;
            t_q         <= '0;
            t_neg       <= '0;
            n_terms     <= '0;
            t_idx       <= '0;
            q_acc       <= '0;
            base_cnt    <= '0;
            pw_lo       <= '0;
            pw_hi       <= '0;
            base        <= '0;
            dvd         <= '0;
            rem         <= '0;
            quo         <= '0;
            div_cnt     <= '0;
            lb_r        <= '0;
            ub_r        <= '0;
            live_r      <= 1'b0;
            half_r      <= '0;
            term_r      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        n_r        <= bus.n_in;
                        mode_r     <= bus.mode_in;
                        acc        <= '0;
                        dig_cnt    <= '0;
                        dig_pow    <= PW'(1);
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= S_DIGS;
                    end
                end

                // One power of ten per cycle; n = 0 leaves the digit count at zero.
                S_DIGS: begin
                    if ({4'b0000, n_r} >= dig_pow) begin
                        dig_cnt <= dig_cnt + 5'd1;
                        dig_pow <= times10(dig_pow);
                    end else begin
                        d_cur <= 5'd2;
                        if (dig_cnt < 5'd2) begin
                            sum_out_r   <= acc;
                            out_valid_r <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            state <= S_TERMS;
                        end
                    end
                end

                // Inclusion-exclusion terms: +p1 [+p2 -p1*p2] in mode 1, +2 for even d in mode 0.
                S_TERMS: begin
                    t_idx <= '0;
                    q_acc <= '0;
                    pw_lo <= PW'(1);
                    pw_hi <= PW'(1);
                    if (!mode_r) begin
                        t_q   <= {5'd0, 5'd0, 5'd0, 5'd2};
                        t_neg <= 4'b0000;
                        if (!d_cur[0]) begin
                            n_terms <= 2'd1;
                            state   <= S_POW;
                        end else begin
                            n_terms <= 2'd0;
                            d_cur   <= d_next;
                            if (more_d) begin
                                state <= S_TERMS;
                            end else begin
                                sum_out_r   <= acc;
                                out_valid_r <= 1'b1;
                                state       <= S_DONE;
                            end
                        end
                    end else begin
                        t_q     <= {5'd0, p12, p2, p1};
                        t_neg   <= 4'b0100;
                        n_terms <= two_primes ? 2'd3 : 2'd1;
                        state   <= S_POW;
                    end
                end

                // Walk q_acc up to d in steps of q: b steps leave pw_hi = 10^b, pw_lo = 10^(b-1).
                S_POW: begin
                    if (q_acc == d_cur) begin
                        base     <= '0;
                        base_cnt <= '0;
                        state    <= S_BASE;
                    end else begin
                        q_acc <= q_acc + cur_q;
                        pw_lo <= pw_hi;
                        pw_hi <= times10(pw_hi);
                    end
                end

                // Horner form of sum_{i<q} 10^(i*b): one multiply-add per cycle.
                S_BASE: begin
                    if (base_cnt == cur_q) begin
                        rem     <= '0;
                        quo     <= '0;
                        dvd     <= n_r;
                        div_cnt <= '0;
                        state   <= S_DIV;
                    end else begin
                        base     <= base * pw_hi + PW'(1);
                        base_cnt <= base_cnt + 5'd1;
                    end
                end

                // Restoring divide n / base, one quotient bit per cycle.
                S_DIV: begin
                    rem     <= rem_ge ? PW'(rem_shift - {1'b0, base}) : rem_shift[PW-1:0];
                    quo     <= {quo[WIDTH-2:0], rem_ge};
                    dvd     <= dvd << 1;
                    div_cnt <= div_cnt + 7'd1;
                    if (div_cnt == 7'(WIDTH - 1)) begin
                        state <= S_RANGE;
                    end
                end

                // Block range [10^(b-1), min(10^b-1, n/base)].
                S_RANGE: begin
                    lb_r  <= pw_lo;
                    ub_r  <= ub_sel;
                    state <= S_MUL1;
                end

                // Arithmetic series sum of the block values; the product is always even.
                S_MUL1: begin
                    live_r <= ub_r >= lb_r;
                    half_r <= (MW'(s_w) * MW'(cnt_w)) >> 1;
                    state  <= S_MUL2;
                end

                // Scale by the base to turn block values into full IDs.
                S_MUL2: begin
                    term_r <= live_r ? (SUM_WIDTH'(base) * SUM_WIDTH'(half_r)) : '0;
                    state  <= S_ACC;
                end

                // Signed accumulate (wraps freely mid-d), then next term or next digit count.
                S_ACC: begin
                    acc <= acc_upd;
                    if ((t_idx + 2'd1) < n_terms) begin
                        t_idx <= t_idx + 2'd1;
                        q_acc <= '0;
                        pw_lo <= PW'(1);
                        pw_hi <= PW'(1);
                        state <= S_POW;
                    end else begin
                        d_cur <= d_next;
                        if (more_d) begin
                            state <= S_TERMS;
                        end else begin
                            sum_out_r   <= acc_upd;
                            out_valid_r <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
                end

                // Hold the result until the consumer takes it.
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rep_sum_engine.sv
// Directed bench for rep_sum_engine: known sums, edge bounds and handshake corners.
// Latency: each request waits on out_valid with a bounded cycle budget.
// Backpressure: exercises held results (out_ready low) and back-to-back requests.
module tb_rep_sum_engine;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    rep_sum_engine_if #(.WIDTH(64), .SUM_WIDTH(128)) bus ();

    rep_sum_engine #(.WIDTH(64), .SUM_WIDTH(128)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock.
    always #5 clock = ~clock;

    // Count completed result handshakes.
    always @(posedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) hs_cnt++;
    end

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [63:0] n, input logic m);
        int w;
        w = 0;
        while (!bus.in_ready && w < 20000) begin
            tick();
            w++;
        end
        check("accept_ready", 128'(bus.in_ready), 128'd1);
        bus.n_in     = n;
        bus.mode_in  = m;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("busy_after_accept", 128'(bus.busy), 128'd1);
    endtask

    task automatic wait_out();
        int w;
        w = 0;
        while (!bus.out_valid && w < 20000) begin
            tick();
            w++;
        end
        check("out_valid_seen", 128'(bus.out_valid), 128'd1);
    endtask

    task automatic run(input string tag, input logic [63:0] n, input logic m, input logic [127:0] exp);
        send(n, m);
        wait_out();
        check(tag, bus.sum_out, exp);
        tick();
        check({tag, "_pulse"}, 128'(bus.out_valid), 128'd0);
    endtask

    // Brute-force reference: sum of x <= n whose digits are one block repeated.
    function automatic longint unsigned model(input longint unsigned n, input bit m);
        longint unsigned s;
        longint unsigned t;
        longint unsigned md;
        longint unsigned blk;
        longint unsigned y;
        int nd;
        int b;
        bit hit;
        bit ok;
        s = 0;
        for (longint unsigned x = 1; x <= n; x++) begin
            nd = 0;
            t  = x;
            while (t > 0) begin
                nd++;
                t = t / 10;
            end
            hit = 1'b0;
            for (int q = 2; q <= nd; q++) begin
                if ((nd % q) == 0 && (m || q == 2)) begin
                    b  = nd / q;
                    md = 1;
                    for (int i = 0; i < b; i++) md = md * 10;
                    blk = x % md;
                    y   = x;
                    ok  = 1'b1;
                    for (int i = 0; i < q; i++) begin
                        if ((y % md) != blk) ok = 1'b0;
                        y = y / md;
                    end
                    if (ok) hit = 1'b1;
                end
            end
            if (hit) s = s + x;
        end
        return s;
    endfunction

    initial begin
        int h0;
        longint unsigned ref6;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.n_in      = '0;
        bus.mode_in   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_sum_out", bus.sum_out, 128'd0);
        reset = 1'b0;
        tick();

        run("n99_m0", 64'd99, 1'b0, 128'd495);
        run("n99_m1", 64'd99, 1'b1, 128'd495);
        run("n999_m0", 64'd999, 1'b0, 128'd495);
        run("n999_m1", 64'd999, 1'b1, 128'd5490);
        run("n9999_m0", 64'd9999, 1'b0, 128'd495900);
        run("n9999_m1", 64'd9999, 1'b1, 128'd500895);
        run("n1234_m0", 64'd1234, 1'b0, 128'd3828);
        run("n1234_m1", 64'd1234, 1'b1, 128'd8823);
        run("n0_m0", 64'd0, 1'b0, 128'd0);
        run("n0_m1", 64'd0, 1'b1, 128'd0);
        run("n10_m1", 64'd10, 1'b1, 128'd0);
        run("n11_m1", 64'd11, 1'b1, 128'd11);
        run("n11_m0", 64'd11, 1'b0, 128'd11);

        ref6 = model(64'd999999, 1'b1);
        run("n999999_m1", 64'd999999, 1'b1, 128'(ref6));

        // Result held while the consumer stalls.
        bus.out_ready = 1'b0;
        send(64'd9999, 1'b0);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 128'(bus.out_valid), 128'd1);
            check("hold_sum", bus.sum_out, 128'd495900);
            check("hold_in_ready", 128'(bus.in_ready), 128'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("release_valid", 128'(bus.out_valid), 128'd0);
        check("release_in_ready", 128'(bus.in_ready), 128'd1);
        check("release_busy", 128'(bus.busy), 128'd0);

        // Abort in the middle of the divider.
        h0 = hs_cnt;
        send(64'd99, 1'b0);
        repeat (30) tick();
        check("abort_busy_before", 128'(bus.busy), 128'd1);
        reset = 1'b1;
        tick();
        check("abort_out_valid", 128'(bus.out_valid), 128'd0);
        check("abort_in_ready", 128'(bus.in_ready), 128'd1);
        check("abort_busy", 128'(bus.busy), 128'd0);
        reset = 1'b0;
        tick();
        check("abort_no_result", 128'(hs_cnt), 128'(h0));
        run("after_abort_n99", 64'd99, 1'b0, 128'd495);

        // Back-to-back requests, out_ready tied high: one handshake per request.
        h0 = hs_cnt;
        run("b2b_a", 64'd99, 1'b1, 128'd495);
        run("b2b_b", 64'd1234, 1'b0, 128'd3828);
        run("b2b_c", 64'd999, 1'b1, 128'd5490);
        repeat (5) tick();
        check("b2b_handshakes", 128'(hs_cnt), 128'(h0 + 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
